// File: rtl/i2s_tx.sv
// i2s_tx: FIFO-buffered stereo I2S transmitter. Sample pairs are queued and shifted
// out MSB first with the standard one-bit delay after each word-select edge.
module i2s_tx #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int I2S_CLK_FREQ = 1_500_000,
    parameter int DATA_SIZE    = 24,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic [DATA_SIZE-1:0]               sample_left,
    input  logic [DATA_SIZE-1:0]               sample_right,
    input  logic                               sample_valid,
    output logic                               sample_ready,
    output logic                               i2s_clk,
    output logic                               i2s_ws,
    output logic                               i2s_sd,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               fifo_empty,
    output logic                               fifo_full,
    output logic                               underrun,
    output logic [15:0]                        underrun_count
);

    localparam int RAW_DIV  = CLK_FREQ / (2 * I2S_CLK_FREQ);
    localparam int HALF_DIV = (RAW_DIV < 1) ? 1 : RAW_DIV;
    localparam int DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int LEVEL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

    logic                 running;
    logic [DIV_W-1:0]     div;
    logic [5:0]           slot;
    logic [DATA_SIZE-1:0] word_left, word_right;
    logic [DATA_SIZE-1:0] mem_left  [FIFO_DEPTH];
    logic [DATA_SIZE-1:0] mem_right [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [LEVEL_W-1:0]   level;

    logic                 tick, fall, load, push, pop;
    logic [5:0]           next_slot;
    logic [DATA_SIZE-1:0] next_left, next_right, src_word, shifted;
    logic                 next_sd;

    assign fifo_level   = level;
    assign fifo_empty   = (level == '0);
    assign fifo_full    = (level == LEVEL_W'(FIFO_DEPTH));
    assign sample_ready = !fifo_full;

    // The divider idles for the cycle enable is first seen, so the first SCK rise
    // lands a full half period after that cycle.
    assign tick      = enable && running && (div == DIV_LAST);
    assign fall      = tick && i2s_clk;
    assign load      = fall && (slot == 6'd0);
    assign push      = sample_valid && sample_ready;
    assign pop       = load && !fifo_empty;
    assign next_slot = slot + 6'd1;

    always_comb begin
        next_left  = word_left;
        next_right = word_right;
        if (load) begin
            if (fifo_empty) begin
                next_left  = '0;
                next_right = '0;
            end else begin
                next_left  = mem_left[rd_ptr];
                next_right = mem_right[rd_ptr];
            end
        end
        // The bit for the new slot belongs to the slot being left (one-bit delay);
        // shifting past DATA_SIZE naturally yields the zero padding.
        src_word = slot[5] ? next_right : next_left;
        shifted  = src_word << slot[4:0];
        next_sd  = shifted[DATA_SIZE-1];
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_left[wr_ptr]  <= sample_left;
            mem_right[wr_ptr] <= sample_right;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      level <= level + LEVEL_W'(1);
            else if (pop && !push) level <= level - LEVEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running        <= 1'b0;
            div            <= '0;
            slot           <= '0;
            i2s_clk        <= 1'b0;
            i2s_ws         <= 1'b0;
            i2s_sd         <= 1'b0;
            word_left      <= '0;
            word_right     <= '0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            running  <= enable;
            underrun <= 1'b0;
            if (!enable) begin
                div        <= '0;
                slot       <= '0;
                i2s_clk    <= 1'b0;
                i2s_ws     <= 1'b0;
                i2s_sd     <= 1'b0;
                word_left  <= '0;
                word_right <= '0;
            end else begin
                if (running) begin
                    if (tick) begin
                        div     <= '0;
                        i2s_clk <= !i2s_clk;
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                if (fall) begin
                    slot       <= next_slot;
                    i2s_ws     <= next_slot[5];
                    i2s_sd     <= next_sd;
                    word_left  <= next_left;
                    word_right <= next_right;
                end
                if (load && fifo_empty) begin
                    underrun <= 1'b1;
                    if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
                end
            end
        end
    end

endmodule
